// File: rtl/serial_adder_pkg.sv
// Shared types for the bit-serial adder.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sa_state_t;

endpackage

// File: rtl/full_adder.sv
// Combinational 1-bit full-adder cell used as the slice of the serial adder.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial W-bit adder: one full_adder slice plus a carry flop, LSB first.
// Optional signed-overflow output enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic         cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic         ovf
`endif
);

  localparam int CNT_W = (W > 1) ? $clog2(W) : 1;

  sa_state_t        state;
  sa_state_t        next_state;
  logic [W-1:0]     a_sr;
  logic [W-1:0]     b_sr;
  logic [W-1:0]     s_sr;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic             rst_hold;
  logic             slice_sum;
  logic             slice_cout;
  logic             last_bit;

  assign last_bit = (cnt == CNT_W'(W - 1));

  full_adder u_slice (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .cin  (carry),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  // rst_hold keeps in_ready low while reset is applied without a comb path from rst.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      rst_hold <= 1'b1;
    end else begin
      state    <= next_state;
      rst_hold <= 1'b0;
    end
  end

  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = ~rst_hold;
        if (in_valid && !rst_hold) next_state = RUN;
      end
      RUN: begin
        if (last_bit) next_state = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Sum bits enter at the MSB so after W shifts S holds the result in place.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr  <= '0;
      b_sr  <= '0;
      s_sr  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_sr  <= a;
            b_sr  <= b;
            carry <= cin;
            cnt   <= '0;
          end
        end
        RUN: begin
          a_sr  <= a_sr >> 1;
          b_sr  <= b_sr >> 1;
          s_sr  <= (s_sr >> 1) | (W'(slice_sum) << (W - 1));
          carry <= slice_cout;
          cnt   <= cnt + CNT_W'(1);
        end
        default: begin
        end
      endcase
    end
  end

`ifdef SERIAL_ADDER_OVF_EN
  logic msb_cin;

  // Carry into the MSB is the carry register during the final RUN cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      msb_cin <= 1'b0;
    end else if (state == RUN && last_bit) begin
      msb_cin <= carry;
    end
  end

  assign ovf = msb_cin ^ carry;
`endif

  assign sum  = s_sr;
  assign cout = carry;

endmodule
